adder_subtractor: RTL and testbench

- Registered two's-complement adder/subtractor. Default width is 6 bits.
- Sel `s`=0 computes a+b; `s`=1 computes a−b, implemented as a + ~b + 1.
- Datapath is a ripple chain of full-adder cells. Result and status flags are registered on the rising clock edge.
- Leaf arithmetic block for small ALU/datapath use.

---
 rtl/adder_subtractor_pkg.sv | 11 +
 rtl/full_adder.sv | 16 +
 rtl/adder_subtractor.sv | 129 ++++++++++++
 tb/tb_adder_subtractor.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/adder_subtractor_pkg.sv
// Shared constants for the registered adder/subtractor.
package adder_subtractor_pkg;

    // Operation select encoding for the s input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default operand/result width
    localparam int unsigned ADDSUB_WIDTH = 6;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; chained by the adder/subtractor to form a ripple adder.
module full_adder (
    input  logic x_i,
    input  logic y_i,
    input  logic ci_i,
    output logic sum_o,
    output logic co_o
);

    // Sum and majority carry
    always_comb begin
        sum_o = x_i ^ y_i ^ ci_i;
        co_o  = (x_i & y_i) | (x_i & ci_i) | (y_i & ci_i);
    end

endmodule

// File: rtl/adder_subtractor.sv
// Registered two's-complement adder/subtractor built from a ripple chain of full_adder cells.
// Subtract is a + ~b + 1. Result and flags update one cycle after a valid input.
// Optional build macro ADDSUB_SATURATE_EN clamps signed overflow to the representable
// extreme instead of wrapping.
module adder_subtractor
    import adder_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             s_i,
    input  logic             in_valid_i,
    output logic [WIDTH-1:0] answer_o,
    output logic             carry_out_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             out_valid_o
);

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] raw;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] answer_q, answer_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    // Operand conditioning: subtract inverts b and injects a carry-in of one
    always_comb begin
        b_eff = b_i;
        cin   = 1'b0;
        case (s_i)
            OP_ADD: begin
                b_eff = b_i;
                cin   = 1'b0;
            end
            OP_SUB: begin
                b_eff = ~b_i;
                cin   = 1'b1;
            end
            default: ;
        endcase
    end

    assign carry[0] = cin;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ripple
        full_adder u_full_adder (
            .x_i   (a_i[i]),
            .y_i   (b_eff[i]),
            .ci_i  (carry[i]),
            .sum_o (raw[i]),
            .co_o  (carry[i+1])
        );
    end

    // MSB carry-out and signed overflow from the carries around the MSB cell
    always_comb begin
        cout = carry[WIDTH];
        ovf  = carry[WIDTH] ^ carry[WIDTH-1];
    end

`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp on overflow: a wrapped negative sign means the true result was too large
    always_comb begin
        result = raw;
        if (ovf) begin
            result = raw[WIDTH-1] ? MaxPos : MinNeg;
        end
    end
`else
    // Plain modulo 2^WIDTH result
    always_comb begin
        result = raw;
    end
`endif

    // Next-state: capture on valid, otherwise hold result/flags and drop out_valid
    always_comb begin
        answer_d = answer_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        if (in_valid_i) begin
            answer_d = result;
            carry_d  = cout;
            ovf_d    = ovf;
            zero_d   = (result == '0);
            valid_d  = 1'b1;
        end
    end

    // Output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            answer_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            answer_q <= answer_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign answer_o    = answer_q;
    assign carry_out_o = carry_q;
    assign overflow_o  = ovf_q;
    assign zero_o      = zero_q;
    assign out_valid_o = valid_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// Self-checking bench for adder_subtractor: directed cases then random traffic,
// compared against an integer-arithmetic reference model.
module tb_adder_subtractor;

    localparam int W    = 6;
    localparam int MASK = (1 << W) - 1;
    localparam int MAXP = (1 << (W - 1)) - 1;
    localparam int MINN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         in_valid;
    logic [W-1:0] answer;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_answer;
    int m_cout;
    int m_ovf;
    int m_zero;
    int m_valid;

    adder_subtractor #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_i         (a),
        .b_i         (b),
        .s_i         (s),
        .in_valid_i  (in_valid),
        .answer_o    (answer),
        .carry_out_o (carry_out),
        .overflow_o  (overflow),
        .zero_o      (zero),
        .out_valid_o (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_answer = 0;
        m_cout   = 0;
        m_ovf    = 0;
        m_zero   = 1;
        m_valid  = 0;
    endtask

    // Signed/unsigned arithmetic straight from the operation definition
    task automatic model_op(input int av, input int bv, input int sv);
        int sa, sb, sres, r;
        sa = (av > MAXP) ? av - (1 << W) : av;
        sb = (bv > MAXP) ? bv - (1 << W) : bv;
        if (sv == 0) begin
            m_cout = ((av + bv) > MASK) ? 1 : 0;
            sres   = sa + sb;
        end else begin
            m_cout = (av >= bv) ? 1 : 0;
            sres   = sa - sb;
        end
        m_ovf = (sres > MAXP || sres < MINN) ? 1 : 0;
        r = sres & MASK;
`ifdef ADDSUB_SATURATE_EN
        if (sres > MAXP) r = MAXP;
        else if (sres < MINN) r = MINN & MASK;
`endif
        m_answer = r;
        m_zero   = (r == 0) ? 1 : 0;
        m_valid  = 1;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_answer"}, 32'(answer), m_answer);
        check_eq({tag, "_carry"}, 32'(carry_out), m_cout);
        check_eq({tag, "_ovf"}, 32'(overflow), m_ovf);
        check_eq({tag, "_zero"}, 32'(zero), m_zero);
        check_eq({tag, "_valid"}, 32'(out_valid), m_valid);
    endtask

    // Drive one cycle of inputs, let an edge pass, then check outputs
    task automatic step(input logic v, input int av, input int bv, input int sv,
                        input string tag);
        in_valid = v;
        a        = av[W-1:0];
        b        = bv[W-1:0];
        s        = sv[0];
        @(posedge clk);
        #1;
        if (v) model_op(av & MASK, bv & MASK, sv);
        else m_valid = 0;
        check_all(tag);
    endtask

    initial begin
        a        = '0;
        b        = '0;
        s        = 1'b0;
        in_valid = 1'b0;
        model_reset();

        // Reset held across an edge
        #12;
        check_all("reset");
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        step(1'b1, 0, 0, 0, "add_0_0");
        step(1'b1, 5, 3, 0, "add_5_3");
        step(1'b1, 3, 5, 1, "sub_3_5");
        step(1'b1, 7, 7, 1, "sub_7_7");
        step(1'b1, 0, 0, 1, "sub_0_0");
        step(1'b1, 31, 1, 0, "ovf_add");
        step(1'b1, 32, 1, 1, "ovf_sub");
        step(1'b0, 12, 9, 1, "hold1");
        step(1'b0, 1, 2, 0, "hold2");
        step(1'b1, 10, 20, 0, "stream1");
        step(1'b1, 63, 63, 1, "stream2");
        step(1'b1, 40, 50, 0, "stream3");

        // Asynchronous reset between edges while streaming
        step(1'b1, 9, 4, 1, "pre_rst");
        in_valid = 1'b1;
        a        = 6'd17;
        b        = 6'd2;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(posedge clk);
        #1;
        check_all("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 17, 2, 0, "post_rst");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, MASK)),
                 int'($urandom_range(0, MASK)), int'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
